up_bus_arbiter: RTL and testbench
=================================

// Module: up_bus_arbiter
// PURPOSE
// Shares one up_* register bus (wreq/waddr/wdata/wack, rreq/raddr/rdata/rack) between NUM_MASTERS
// requesters, e.g. the AXI bridge and an internal DAC config sequencer. Slaves are the TPL DAC common/channel regmaps.
// Round-robin grant, one transaction on the bus at a time, timeout so a missing ack cannot hang a master.
// PARAMETERS
// NUM_MASTERS    2    number of requesters (1..8)
// ADDR_WIDTH     14   up_waddr/up_raddr width
// TIMEOUT        255  cycles to wait for slave ack before error completion (1..255, 8-bit counter)
// PORTS
// up_clk         in   1               register-bus clock; only clock
// up_rst         in   1               asynchronous, active-high reset
// m_wreq         in   NUM_MASTERS     per-master write request, 1-cycle pulse
// m_waddr        in   NUM_MASTERS*AW  write address, valid with m_wreq
// m_wdata        in   NUM_MASTERS*32  write data, valid with m_wreq
// m_wack         out  NUM_MASTERS     write completion pulse to owner
// m_rreq         in   NUM_MASTERS     per-master read request, 1-cycle pulse
// m_raddr        in   NUM_MASTERS*AW  read address, valid with m_rreq
// m_rack         out  NUM_MASTERS     read completion pulse to owner
// m_rdata        out  32              read data, valid only with an m_rack bit
// m_err          out  NUM_MASTERS     pulses with m_wack/m_rack when completion was a timeout
// up_wreq/up_waddr/up_wdata  out 1/AW/32  slave write request (1-cycle pulse)
// up_wack        in   1               slave write ack (OR of all slaves)
// up_rreq/up_raddr out 1/AW           slave read request (1-cycle pulse)
// up_rdata/up_rack in 32/1            slave read data, valid with up_rack
// busy           out  1               high whenever state != IDLE
// BEHAVIOUR
// - Reset: all outputs 0, pending bits cleared, rr pointer = 0, state IDLE; async assert, sync-released use of up_clk.
// - Capture: m_wreq/m_rreq pulse latches addr/data into per-master slot and sets pend_w[m]/pend_r[m] next edge.
//   Req while the same-kind pend bit is already set is dropped (one outstanding per master per kind).
// - States: IDLE -> WR_WAIT | RD_WAIT -> IDLE.
//   IDLE: if any pend, pick first master at/after rr pointer with pend_w|pend_r; write served before read
//   for the same master; drive up_wreq or up_rreq for exactly one cycle (registered), load timer=0, go WAIT.
//   WAIT: timer++ each cycle; on up_wack (WR) / up_rack (RD): next cycle pulse m_wack[g]/m_rack[g],
//   m_rdata<=up_rdata (RD), clear pend bit, rr pointer <= g+1 (mod NUM_MASTERS), go IDLE.
//   Timeout: timer==TIMEOUT and no ack -> same completion with m_err[g]=1, m_rdata=32'hDEAD_DEAD.
//   Ack and timeout in same cycle: ack wins, m_err=0.
// - Wrong-kind or stray acks (up_rack in WR_WAIT, any ack in IDLE) ignored.
// - Latency: req at cycle t -> up_*req at t+2; slave ack at cycle k -> m_*ack at k+1. Min round trip 4 cycles.
// - Only one of m_wack/m_rack bits high per cycle; m_rdata holds last value otherwise.
// - Back-to-back: IDLE lasts exactly one cycle when pend is non-empty; no bus idle gap beyond it.
// - Reset mid-transaction: transaction dropped, no ack/err ever issued for it; masters must re-issue.
// - up_waddr/up_wdata/up_raddr held stable from request until ack/timeout.
// STRUCTURE
// - No shared package; state encodings and 32'hDEAD_DEAD poison value are localparams here.
// - One sub-module: up_rr_pick (NUM_MASTERS-wide request vector + pointer -> one-hot grant + index),
//   combinational, reusable by other up_* arbiters.
// - Remainder: capture slots, FSM, timer, completion register, in this module.
// TESTING
// - Single write m0 addr 0x0040 data 0x1234_5678, slave acks 1 cycle later -> up_wreq at t+2, m_wack[0] at t+4, m_err=0.
// - Simultaneous m_rreq[0] and m_rreq[1], rr=0 -> m0 served first, then m1; rr ends at 0; rdata returned per owner.
// - Same master wreq+rreq same cycle -> write issued first, read issued 1 cycle after write completion.
// - Slave never acks a read, TIMEOUT=16 -> m_rack+m_err at 17 cycles after up_rreq, m_rdata=0xDEAD_DEAD.
// - up_rack coincident with timer==TIMEOUT -> m_rack with real data, m_err=0.
// - up_rst pulsed during RD_WAIT -> no m_rack, busy=0, pend cleared; next request completes normally.

Source files
------------

// File: rtl/up_bus_arbiter_if.sv
// up_* register-bus bundle: per-requester request/completion signals plus the shared slave bus.
// arb is the arbiter's view, master the requesters', slave the regmaps'.
interface up_bus_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_WIDTH  = 14
);
  // Requester side, packed per master
  logic [NUM_MASTERS-1:0]            m_wreq;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_waddr;
  logic [NUM_MASTERS*32-1:0]         m_wdata;
  logic [NUM_MASTERS-1:0]            m_wack;
  logic [NUM_MASTERS-1:0]            m_rreq;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_raddr;
  logic [NUM_MASTERS-1:0]            m_rack;
  logic [31:0]                       m_rdata;
  logic [NUM_MASTERS-1:0]            m_err;

  // Shared slave bus
  logic                  up_wreq;
  logic [ADDR_WIDTH-1:0] up_waddr;
  logic [31:0]           up_wdata;
  logic                  up_wack;
  logic                  up_rreq;
  logic [ADDR_WIDTH-1:0] up_raddr;
  logic [31:0]           up_rdata;
  logic                  up_rack;

  logic busy;

  modport arb (
    input  m_wreq, m_waddr, m_wdata, m_rreq, m_raddr, up_wack, up_rdata, up_rack,
    output m_wack, m_rack, m_rdata, m_err, up_wreq, up_waddr, up_wdata, up_rreq, up_raddr, busy
  );

  modport master (
    output m_wreq, m_waddr, m_wdata, m_rreq, m_raddr,
    input  m_wack, m_rack, m_rdata, m_err, busy
  );

  modport slave (
    input  up_wreq, up_waddr, up_wdata, up_rreq, up_raddr,
    output up_wack, up_rdata, up_rack
  );
endinterface

// File: rtl/up_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer, as one-hot and index.
module up_rr_pick #(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    i_req,
  input  logic [IdxW-1:0] i_ptr,
  output logic [N-1:0]    o_gnt,
  output logic [IdxW-1:0] o_idx,
  output logic            o_valid
);
  logic [IdxW-1:0] w_k;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_k     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_k = IdxW'((32'(i_ptr) + i) % N);
      if (!o_valid && i_req[w_k]) begin
        o_valid    = 1'b1;
        o_gnt[w_k] = 1'b1;
        o_idx      = w_k;
      end
    end
  end
endmodule

// File: rtl/up_bus_arbiter.sv
// Round-robin sharing of one up_* register bus between NUM_MASTERS requesters, one transaction
// at a time, with a per-transaction ack timeout that completes with m_err and poisoned read data.
module up_bus_arbiter #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_WIDTH  = 14,
  parameter int unsigned TIMEOUT     = 255
) (
  input logic             up_clk,
  input logic             up_rst,
  up_bus_arbiter_if.arb   bus
);
  localparam int unsigned IdxW   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [31:0] Poison = 32'hDEAD_DEAD;

  typedef enum logic [1:0] {StIdle, StWrWait, StRdWait} state_e;

  state_e                  r_state;
  logic [NUM_MASTERS-1:0]  r_pend_w, r_pend_r;
  logic [ADDR_WIDTH-1:0]   r_waddr_slot [NUM_MASTERS];
  logic [31:0]             r_wdata_slot [NUM_MASTERS];
  logic [ADDR_WIDTH-1:0]   r_raddr_slot [NUM_MASTERS];
  logic [IdxW-1:0]         r_ptr, r_gnt_idx;
  logic [NUM_MASTERS-1:0]  r_gnt_oh;
  logic [7:0]              r_timer;

  logic                    r_up_wreq, r_up_rreq;
  logic [ADDR_WIDTH-1:0]   r_up_waddr, r_up_raddr;
  logic [31:0]             r_up_wdata;
  logic [NUM_MASTERS-1:0]  r_m_wack, r_m_rack, r_m_err;
  logic [31:0]             r_m_rdata;

  logic [NUM_MASTERS-1:0]  w_pend, w_gnt;
  logic [IdxW-1:0]         w_idx, w_ptr_next;
  logic                    w_valid, w_timeout, w_wr_done, w_rd_done;

  assign w_pend     = r_pend_w | r_pend_r;
  assign w_timeout  = (r_timer == 8'(TIMEOUT));
  assign w_wr_done  = (r_state == StWrWait) && (bus.up_wack || w_timeout);
  assign w_rd_done  = (r_state == StRdWait) && (bus.up_rack || w_timeout);
  assign w_ptr_next = (r_gnt_idx == IdxW'(NUM_MASTERS - 1)) ? '0 : r_gnt_idx + 1'b1;

  up_rr_pick #(
    .N    (NUM_MASTERS),
    .IdxW (IdxW)
  ) u_pick (
    .i_req   (w_pend),
    .i_ptr   (r_ptr),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  // Capture slots: a slot is frozen while its pend bit is set, so the bus sees stable addr/data.
  // Completion clear wins over a same-cycle new request, which is dropped as a duplicate.
  always_ff @(posedge up_clk or posedge up_rst) begin
    if (up_rst) begin
      r_pend_w <= '0;
      r_pend_r <= '0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        r_waddr_slot[i] <= '0;
        r_wdata_slot[i] <= '0;
        r_raddr_slot[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        if (w_wr_done && r_gnt_oh[i]) begin
          r_pend_w[i] <= 1'b0;
        end else if (bus.m_wreq[i] && !r_pend_w[i]) begin
          r_pend_w[i]     <= 1'b1;
          r_waddr_slot[i] <= bus.m_waddr[i*ADDR_WIDTH +: ADDR_WIDTH];
          r_wdata_slot[i] <= bus.m_wdata[i*32 +: 32];
        end
        if (w_rd_done && r_gnt_oh[i]) begin
          r_pend_r[i] <= 1'b0;
        end else if (bus.m_rreq[i] && !r_pend_r[i]) begin
          r_pend_r[i]     <= 1'b1;
          r_raddr_slot[i] <= bus.m_raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge up_clk or posedge up_rst) begin
    if (up_rst) begin
      r_state    <= StIdle;
      r_ptr      <= '0;
      r_gnt_idx  <= '0;
      r_gnt_oh   <= '0;
      r_timer    <= '0;
      r_up_wreq  <= 1'b0;
      r_up_rreq  <= 1'b0;
      r_up_waddr <= '0;
      r_up_wdata <= '0;
      r_up_raddr <= '0;
      r_m_wack   <= '0;
      r_m_rack   <= '0;
      r_m_err    <= '0;
      r_m_rdata  <= '0;
    end else begin
      r_up_wreq <= 1'b0;
      r_up_rreq <= 1'b0;
      r_m_wack  <= '0;
      r_m_rack  <= '0;
      r_m_err   <= '0;
      case (r_state)
        StIdle: begin
          if (w_valid) begin
            r_gnt_idx <= w_idx;
            r_gnt_oh  <= w_gnt;
            r_timer   <= '0;
            // Write goes first when the same master has both kinds pending
            if (r_pend_w[w_idx]) begin
              r_up_wreq  <= 1'b1;
              r_up_waddr <= r_waddr_slot[w_idx];
              r_up_wdata <= r_wdata_slot[w_idx];
              r_state    <= StWrWait;
            end else begin
              r_up_rreq  <= 1'b1;
              r_up_raddr <= r_raddr_slot[w_idx];
              r_state    <= StRdWait;
            end
          end
        end
        StWrWait: begin
          if (w_wr_done) begin
            r_m_wack <= r_gnt_oh;
            r_m_err  <= bus.up_wack ? '0 : r_gnt_oh;
            r_ptr    <= w_ptr_next;
            r_state  <= StIdle;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        StRdWait: begin
          if (w_rd_done) begin
            r_m_rack  <= r_gnt_oh;
            r_m_err   <= bus.up_rack ? '0 : r_gnt_oh;
            r_m_rdata <= bus.up_rack ? bus.up_rdata : Poison;
            r_ptr     <= w_ptr_next;
            r_state   <= StIdle;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.up_wreq  = r_up_wreq;
  assign bus.up_waddr = r_up_waddr;
  assign bus.up_wdata = r_up_wdata;
  assign bus.up_rreq  = r_up_rreq;
  assign bus.up_raddr = r_up_raddr;
  assign bus.m_wack   = r_m_wack;
  assign bus.m_rack   = r_m_rack;
  assign bus.m_err    = r_m_err;
  assign bus.m_rdata  = r_m_rdata;
  assign bus.busy     = (r_state != StIdle);
endmodule

// File: tb/tb_up_bus_arbiter.sv
// Bench for up_bus_arbiter: scripted scenarios, a slave model and a completion scoreboard.
module tb_up_bus_arbiter;
  localparam int unsigned NM = 2;
  localparam int unsigned AW = 14;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  up_bus_arbiter_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW)) bus ();

  up_bus_arbiter #(
    .NUM_MASTERS (NM),
    .ADDR_WIDTH  (AW),
    .TIMEOUT     (TO)
  ) dut (
    .up_clk (clk),
    .up_rst (rst),
    .bus    (bus)
  );

  typedef struct {
    int unsigned m;
    bit          rd;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Slave model: acks slv_delay cycles after the request; injection lines add stray acks.
  logic        slv_wack  = 1'b0;
  logic        slv_rack  = 1'b0;
  logic [31:0] slv_rdata = 32'hBAD0_BAD0;
  logic        inj_wack  = 1'b0;
  logic        inj_rack  = 1'b0;
  bit          slv_en    = 1'b1;
  int          slv_delay = 1;
  bit          s_rd;
  logic [AW-1:0] s_addr;

  assign bus.up_wack  = slv_wack | inj_wack;
  assign bus.up_rack  = slv_rack | inj_rack;
  assign bus.up_rdata = slv_rdata;

  function automatic logic [31:0] model_rdata(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | {18'h0, a};
  endfunction

  always begin
    @(negedge clk);
    if (!rst && slv_en && (bus.up_wreq || bus.up_rreq)) begin
      s_rd   = bus.up_rreq;
      s_addr = bus.up_raddr;
      repeat (slv_delay) @(negedge clk);
      if (s_rd) begin
        slv_rack  = 1'b1;
        slv_rdata = model_rdata(s_addr);
      end else begin
        slv_wack = 1'b1;
      end
      @(negedge clk);
      slv_rack  = 1'b0;
      slv_wack  = 1'b0;
      slv_rdata = 32'hBAD0_BAD0;
    end
  end

  // Event log and scoreboard
  int            wreq_q[$], rreq_q[$], wack_q[$], rack_q[$];
  logic [AW-1:0] last_waddr;
  logic [31:0]   last_wdata;
  exp_t          e;
  bit            mon_rd;
  logic [NM-1:0] mon_vec, exp_vec, exp_err;

  always @(negedge clk) begin
    if (bus.up_wreq) begin
      wreq_q.push_back(cyc);
      last_waddr = bus.up_waddr;
      last_wdata = bus.up_wdata;
    end
    if (bus.up_rreq) rreq_q.push_back(cyc);
    if ((bus.m_wack | bus.m_rack) != '0) begin
      n_checks++;
      if (bus.m_wack != '0) wack_q.push_back(cyc);
      else rack_q.push_back(cyc);
      if (!$onehot({bus.m_wack, bus.m_rack})) begin
        $display("FAIL completion_onehot: wack=%b rack=%b, required exactly one bit",
                 bus.m_wack, bus.m_rack);
      end else if (sb.size() == 0) begin
        $display("FAIL unexpected_completion @%0d: wack=%b rack=%b err=%b, required none",
                 cyc, bus.m_wack, bus.m_rack, bus.m_err);
      end else begin
        e       = sb.pop_front();
        mon_rd  = (bus.m_rack != '0);
        mon_vec = mon_rd ? bus.m_rack : bus.m_wack;
        exp_vec = '0;
        exp_vec[e.m] = 1'b1;
        exp_err = e.err ? exp_vec : '0;
        if (mon_vec !== exp_vec || mon_rd != e.rd || bus.m_err !== exp_err ||
            (e.rd && bus.m_rdata !== e.data)) begin
          $display("FAIL completion @%0d: got %s vec=%b err=%b rdata=%h, required %s vec=%b err=%b rdata=%h",
                   cyc, mon_rd ? "rd" : "wr", mon_vec, bus.m_err, bus.m_rdata,
                   e.rd ? "rd" : "wr", exp_vec, exp_err, e.data);
        end else begin
          n_pass++;
        end
      end
    end else if (bus.m_err != '0) begin
      n_checks++;
      $display("FAIL stray_err @%0d: m_err=%b, required 0", cyc, bus.m_err);
    end
  end

  task automatic push_exp(input int unsigned m, input bit rd, input logic [31:0] d, input bit err);
    exp_t x;
    x.m = m; x.rd = rd; x.data = d; x.err = err;
    sb.push_back(x);
  endtask

  task automatic clear_logs();
    wreq_q.delete(); rreq_q.delete(); wack_q.delete(); rack_q.delete();
  endtask

  task automatic pulse(input logic [NM-1:0] wm, input logic [NM-1:0] rm, output int t);
    @(posedge clk); #1;
    bus.m_wreq = wm;
    bus.m_rreq = rm;
    t = cyc;
    @(posedge clk); #1;
    bus.m_wreq = '0;
    bus.m_rreq = '0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k = 0;
    while ((sb.size() != 0 || bus.busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (sb.size() != 0 || bus.busy)
      $display("FAIL %s_wait: pending=%0d busy=%0b after %0d cycles, required 0/0",
               name, sb.size(), bus.busy, budget);
    else n_pass++;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", bus.busy);
    else n_pass++;
    n_checks++;
    if ({bus.up_wreq, bus.up_rreq} !== 2'b00)
      $display("FAIL reset_upreq: got %b, required 00", {bus.up_wreq, bus.up_rreq});
    else n_pass++;
    n_checks++;
    if ({bus.m_wack, bus.m_rack, bus.m_err} !== '0)
      $display("FAIL reset_mack: got %b, required 0", {bus.m_wack, bus.m_rack, bus.m_err});
    else n_pass++;
    n_checks++;
    if (bus.m_rdata !== 32'h0) $display("FAIL reset_rdata: got %h, required 0", bus.m_rdata);
    else n_pass++;
    n_checks++;
    if ({bus.up_waddr, bus.up_wdata, bus.up_raddr} !== '0)
      $display("FAIL reset_upbus: got %h %h %h, required 0", bus.up_waddr, bus.up_wdata,
               bus.up_raddr);
    else n_pass++;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (wreq_q.size() + rreq_q.size() != 0)
      $display("FAIL reset_idle: got %0d bus requests, required 0", wreq_q.size() + rreq_q.size());
    else n_pass++;
  endtask

  task automatic test_single_write();
    int t;
    clear_logs();
    slv_en = 1'b1; slv_delay = 1;
    bus.m_waddr[0 +: AW] = 14'h0040;
    bus.m_wdata[0 +: 32] = 32'h1234_5678;
    push_exp(0, 1'b0, 32'h0, 1'b0);
    pulse(2'b01, 2'b00, t);
    wait_done(40, "single_write");
    n_checks++;
    if (wreq_q.size() != 1 || wreq_q[0] != t + 2)
      $display("FAIL sw_upreq_cycle: got n=%0d at %0d, required 1 at %0d",
               wreq_q.size(), wreq_q[0], t + 2);
    else n_pass++;
    n_checks++;
    if (last_waddr !== 14'h0040 || last_wdata !== 32'h1234_5678)
      $display("FAIL sw_upbus: got %h/%h, required 0040/12345678", last_waddr, last_wdata);
    else n_pass++;
    n_checks++;
    if (wack_q[0] != t + 4)
      $display("FAIL sw_wack_cycle: got %0d, required %0d", wack_q[0], t + 4);
    else n_pass++;
  endtask

  task automatic test_rr_reads();
    int t;
    reset_dut();
    clear_logs();
    slv_en = 1'b1; slv_delay = 1;
    bus.m_raddr[0 +: AW]  = 14'h0011;
    bus.m_raddr[AW +: AW] = 14'h0022;
    push_exp(0, 1'b1, model_rdata(14'h0011), 1'b0);
    push_exp(1, 1'b1, model_rdata(14'h0022), 1'b0);
    pulse(2'b00, 2'b11, t);
    wait_done(40, "rr_reads");
    n_checks++;
    if (rreq_q.size() != 2 || rreq_q[0] != t + 2 || rreq_q[1] != t + 5)
      $display("FAIL rr_upreq_cycles: got n=%0d %0d,%0d, required 2 %0d,%0d",
               rreq_q.size(), rreq_q[0], rreq_q[1], t + 2, t + 5);
    else n_pass++;
    n_checks++;
    if (rack_q.size() != 2 || rack_q[0] != t + 4 || rack_q[1] != t + 7)
      $display("FAIL rr_rack_cycles: got n=%0d %0d,%0d, required 2 %0d,%0d",
               rack_q.size(), rack_q[0], rack_q[1], t + 4, t + 7);
    else n_pass++;
    // Pointer wrapped back to 0: m0 first again
    bus.m_raddr[0 +: AW]  = 14'h0123;
    bus.m_raddr[AW +: AW] = 14'h0456;
    push_exp(0, 1'b1, model_rdata(14'h0123), 1'b0);
    push_exp(1, 1'b1, model_rdata(14'h0456), 1'b0);
    pulse(2'b00, 2'b11, t);
    wait_done(40, "rr_reads2");
    // After serving m0 the pointer is 1: m1 must win the next contention
    bus.m_waddr[0 +: AW] = 14'h0008;
    bus.m_wdata[0 +: 32] = 32'hCAFE_0001;
    push_exp(0, 1'b0, 32'h0, 1'b0);
    pulse(2'b01, 2'b00, t);
    wait_done(40, "rr_write");
    bus.m_raddr[0 +: AW]  = 14'h0aaa;
    bus.m_raddr[AW +: AW] = 14'h0bbb;
    push_exp(1, 1'b1, model_rdata(14'h0bbb), 1'b0);
    push_exp(0, 1'b1, model_rdata(14'h0aaa), 1'b0);
    pulse(2'b00, 2'b11, t);
    wait_done(40, "rr_rotate");
  endtask

  task automatic test_wr_rd_same();
    int t;
    clear_logs();
    slv_en = 1'b1; slv_delay = 2;
    bus.m_waddr[AW +: AW] = 14'h0333;
    bus.m_wdata[32 +: 32] = 32'h5555_AAAA;
    bus.m_raddr[AW +: AW] = 14'h0334;
    push_exp(1, 1'b0, 32'h0, 1'b0);
    push_exp(1, 1'b1, model_rdata(14'h0334), 1'b0);
    pulse(2'b10, 2'b10, t);
    wait_done(40, "wr_rd_same");
    n_checks++;
    if (wreq_q.size() != 1 || wreq_q[0] != t + 2)
      $display("FAIL wrrd_write_first: got n=%0d at %0d, required 1 at %0d",
               wreq_q.size(), wreq_q[0], t + 2);
    else n_pass++;
    n_checks++;
    if (rreq_q.size() != 1 || rreq_q[0] != wack_q[0] + 1)
      $display("FAIL wrrd_read_after: got n=%0d at %0d, required 1 at %0d",
               rreq_q.size(), rreq_q[0], wack_q[0] + 1);
    else n_pass++;
  endtask

  task automatic test_drop_duplicate();
    int t, t2;
    clear_logs();
    slv_en = 1'b1; slv_delay = 3;
    bus.m_waddr[0 +: AW] = 14'h0101;
    bus.m_wdata[0 +: 32] = 32'h0000_0101;
    push_exp(0, 1'b0, 32'h0, 1'b0);
    pulse(2'b01, 2'b00, t);
    bus.m_waddr[0 +: AW] = 14'h0202;
    bus.m_wdata[0 +: 32] = 32'h0000_0202;
    pulse(2'b01, 2'b00, t2);
    wait_done(40, "drop");
    repeat (10) @(negedge clk);
    n_checks++;
    if (wreq_q.size() != 1 || last_waddr !== 14'h0101 || last_wdata !== 32'h0000_0101)
      $display("FAIL drop_dup: got n=%0d last %h/%h, required 1 0101/00000101",
               wreq_q.size(), last_waddr, last_wdata);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int t;
    clear_logs();
    slv_en = 1'b0;
    bus.m_raddr[0 +: AW] = 14'h0100;
    push_exp(0, 1'b1, 32'hDEAD_DEAD, 1'b1);
    pulse(2'b00, 2'b01, t);
    wait_done(60, "timeout");
    n_checks++;
    if (rreq_q.size() != 1 || rack_q[0] != rreq_q[0] + 17)
      $display("FAIL timeout_cycle: got rack %0d, required %0d", rack_q[0], rreq_q[0] + 17);
    else n_pass++;
  endtask

  task automatic test_ack_at_timeout();
    int t;
    clear_logs();
    slv_en = 1'b1; slv_delay = 16;
    bus.m_raddr[AW +: AW] = 14'h0200;
    push_exp(1, 1'b1, model_rdata(14'h0200), 1'b0);
    pulse(2'b00, 2'b10, t);
    wait_done(60, "ack_at_timeout");
    n_checks++;
    if (rreq_q.size() != 1 || rack_q[0] != rreq_q[0] + 17)
      $display("FAIL ack_timeout_cycle: got rack %0d, required %0d", rack_q[0], rreq_q[0] + 17);
    else n_pass++;
  endtask

  task automatic test_stray_ack();
    int t;
    clear_logs();
    slv_en = 1'b0;
    @(negedge clk); inj_wack = 1'b1; inj_rack = 1'b1;
    @(negedge clk); inj_wack = 1'b0; inj_rack = 1'b0;
    bus.m_waddr[0 +: AW] = 14'h0300;
    bus.m_wdata[0 +: 32] = 32'h0BAD_F00D;
    push_exp(0, 1'b0, 32'h0, 1'b1);
    pulse(2'b01, 2'b00, t);
    repeat (3) @(negedge clk);
    inj_rack = 1'b1;
    @(negedge clk);
    inj_rack = 1'b0;
    wait_done(60, "stray_ack");
    n_checks++;
    if (wreq_q.size() != 1 || wack_q[0] != wreq_q[0] + 17)
      $display("FAIL stray_rack_ignored: got wack %0d, required %0d", wack_q[0], wreq_q[0] + 17);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int t;
    clear_logs();
    slv_en = 1'b0;
    bus.m_raddr[0 +: AW] = 14'h0055;
    pulse(2'b00, 2'b01, t);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || rreq_q.size() != 1)
      $display("FAIL rstmid_busy: got busy=%b reqs=%0d, required 0/1", bus.busy, rreq_q.size());
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    n_checks++;
    if (rreq_q.size() != 1 || rack_q.size() != 0)
      $display("FAIL rstmid_dropped: got reqs=%0d racks=%0d, required 1/0",
               rreq_q.size(), rack_q.size());
    else n_pass++;
    slv_en = 1'b1; slv_delay = 1;
    bus.m_raddr[AW +: AW] = 14'h0077;
    push_exp(1, 1'b1, model_rdata(14'h0077), 1'b0);
    pulse(2'b00, 2'b10, t);
    wait_done(40, "rstmid_next");
    n_checks++;
    if (rreq_q.size() != 2 || rreq_q[1] != t + 2)
      $display("FAIL rstmid_next_cycle: got n=%0d at %0d, required 2 at %0d",
               rreq_q.size(), rreq_q[1], t + 2);
    else n_pass++;
  endtask

  initial begin
    bus.m_wreq  = '0;
    bus.m_rreq  = '0;
    bus.m_waddr = '0;
    bus.m_wdata = '0;
    bus.m_raddr = '0;
    test_reset();
    test_single_write();
    test_rr_reads();
    test_wr_rd_same();
    test_drop_duplicate();
    test_timeout();
    test_ack_at_timeout();
    test_stray_ack();
    test_reset_mid();
    repeat (5) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d left, required 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
